// File: rtl/sensor_seq_pkg.sv
// Shared encodings for the parking-lot sensor stimulus generator:
// FSM states, {a,b} line patterns per direction, and the hold-counter width.
package sensor_seq_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
    P3   = 3'd3,
    GAP  = 3'd4
  } state_t;

  // {a,b} patterns: a car entering breaks A first, a car leaving breaks B first.
  localparam logic [1:0] ENTER_P1 = 2'b10;
  localparam logic [1:0] ENTER_P2 = 2'b11;
  localparam logic [1:0] ENTER_P3 = 2'b01;
  localparam logic [1:0] EXIT_P1  = 2'b01;
  localparam logic [1:0] EXIT_P2  = 2'b11;
  localparam logic [1:0] EXIT_P3  = 2'b10;
  localparam logic [1:0] GAP_PAT  = 2'b00;

  function automatic logic [1:0] pattern(input state_t s, input logic entering);
    case (s)
      P1:      pattern = entering ? ENTER_P1 : EXIT_P1;
      P2:      pattern = entering ? ENTER_P2 : EXIT_P2;
      P3:      pattern = entering ? ENTER_P3 : EXIT_P3;
      default: pattern = GAP_PAT;
    endcase
  endfunction

endpackage

// File: rtl/sensor_seq_gen_phase_timer.sv
// Loadable 8-bit down-counter timing each phase; expire is high while the count is 0.
module phase_timer
  import sensor_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/sensor_seq_gen.sv
// Drives the a/b optical-barrier lines through an entering or exiting car pattern.
// Optional SENSOR_SEQ_GEN_ABORT_EN adds abort/aborted (car backing out mid-sequence).
module sensor_seq_gen
  import sensor_seq_pkg::*;
#(
  parameter int HOLD = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req_in,
  input  logic req_out,
  output logic ready,
  output logic done,
  output logic dir,
  output logic a,
  output logic b
`ifdef SENSOR_SEQ_GEN_ABORT_EN
  ,
  input  logic abort,
  output logic aborted
`endif
);

  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD - 1);

  state_t state;
  logic   expire;
  logic   start;
  logic   abort_hit;
  logic   load;

  assign start = (state == IDLE) && (req_in || req_out);

`ifdef SENSOR_SEQ_GEN_ABORT_EN
  logic was_aborted;
  assign abort_hit = abort && ((state == P1) || (state == P2));
`else
  assign abort_hit = 1'b0;
`endif

  // Every phase entry reloads the timer; leaving GAP for IDLE does not.
  assign load = start || abort_hit ||
                (expire && ((state == P1) || (state == P2) || (state == P3)));

  phase_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (HOLD_M1),
    .expire   (expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      a      <= 1'b0;
      b      <= 1'b0;
      ready  <= 1'b1;
      done   <= 1'b0;
      dir    <= 1'b0;
`ifdef SENSOR_SEQ_GEN_ABORT_EN
      was_aborted <= 1'b0;
      aborted     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef SENSOR_SEQ_GEN_ABORT_EN
      aborted <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            state  <= P1;
            dir    <= req_in;
            ready  <= 1'b0;
            {a, b} <= pattern(P1, req_in);
`ifdef SENSOR_SEQ_GEN_ABORT_EN
            was_aborted <= 1'b0;
`endif
          end
        end
        P1: begin
`ifdef SENSOR_SEQ_GEN_ABORT_EN
          if (abort_hit) begin
            state       <= GAP;
            {a, b}      <= GAP_PAT;
            was_aborted <= 1'b1;
          end else if (expire) begin
            // A backed-out car re-shows P1 and then clears the barrier.
            state  <= was_aborted ? GAP : P2;
            {a, b} <= was_aborted ? GAP_PAT : pattern(P2, dir);
          end
`else
          if (expire) begin
            state  <= P2;
            {a, b} <= pattern(P2, dir);
          end
`endif
        end
        P2: begin
`ifdef SENSOR_SEQ_GEN_ABORT_EN
          if (abort_hit) begin
            state       <= P1;
            {a, b}      <= pattern(P1, dir);
            was_aborted <= 1'b1;
          end else
`endif
          if (expire) begin
            state  <= P3;
            {a, b} <= pattern(P3, dir);
          end
        end
        P3: begin
          if (expire) begin
            state  <= GAP;
            {a, b} <= GAP_PAT;
          end
        end
        GAP: begin
          if (expire) begin
            state <= IDLE;
            ready <= 1'b1;
            done  <= 1'b1;
`ifdef SENSOR_SEQ_GEN_ABORT_EN
            aborted <= was_aborted;
`endif
          end
        end
        default: begin
          state  <= IDLE;
          ready  <= 1'b1;
          {a, b} <= GAP_PAT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_seq_gen.sv
// Self-checking bench: directed scenarios plus random requests, compared each cycle
// against a timeline model that queues the expected {a,b} per future cycle.
module tb_sensor_seq_gen;

  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req_in = 1'b0;
  logic req_out = 1'b0;
  logic abort = 1'b0;
  logic ready, done, dir, a, b, aborted;

`ifdef SENSOR_SEQ_GEN_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
  assign aborted = 1'b0;
`endif

  sensor_seq_gen #(.HOLD(HOLD)) dut (
    .clk     (clk),
    .reset   (reset),
    .req_in  (req_in),
    .req_out (req_out),
    .ready   (ready),
    .done    (done),
    .dir     (dir),
    .a       (a),
    .b       (b)
`ifdef SENSOR_SEQ_GEN_ABORT_EN
    ,
    .abort   (abort),
    .aborted (aborted)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int done_seen = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Model: phase tag 0=idle, 1..3=pattern phases, 4=gap; one slot per future cycle.
  typedef struct {
    logic [1:0] ab;
    int         ph;
  } slot_t;

  slot_t q[$];
  slot_t last = '{2'b00, 0};
  bit    mdir = 1'b0;
  bit    mab  = 1'b0;

  function automatic logic [1:0] pat(input int ph, input bit entering);
    case (ph)
      1:       pat = entering ? 2'b10 : 2'b01;
      2:       pat = 2'b11;
      3:       pat = entering ? 2'b01 : 2'b10;
      default: pat = 2'b00;
    endcase
  endfunction

  task automatic step();
    slot_t item;
    bit    m_done;
    @(posedge clk);
    item = '{2'b00, 0};
    if (!reset) begin
      q.delete();
      mdir = 1'b0;
      mab  = 1'b0;
    end else if (last.ph == 0 && (req_in || req_out)) begin
      mdir = req_in;
      mab  = 1'b0;
      q.delete();
      for (int p = 1; p <= 4; p++)
        for (int h = 0; h < HOLD; h++) q.push_back('{pat(p, mdir), p});
      item = q.pop_front();
    end else if (ABORT_EN && abort && (last.ph == 1 || last.ph == 2)) begin
      q.delete();
      if (last.ph == 2)
        for (int h = 0; h < HOLD; h++) q.push_back('{pat(1, mdir), 1});
      for (int h = 0; h < HOLD; h++) q.push_back('{2'b00, 4});
      mab  = 1'b1;
      item = q.pop_front();
    end else if (q.size() > 0) begin
      item = q.pop_front();
    end
    m_done = reset && (last.ph == 4) && (item.ph == 0);
    last = item;
    #1;
    check("ab",      {6'd0, a, b}, {6'd0, item.ab});
    check("ready",   {7'd0, ready}, {7'd0, item.ph == 0});
    check("done",    {7'd0, done}, {7'd0, m_done});
    check("dir",     {7'd0, dir}, {7'd0, mdir});
    check("aborted", {7'd0, aborted}, {7'd0, m_done && mab && ABORT_EN});
    if (done) done_seen++;
  endtask

  initial begin
    // Reset held for 3 cycles, then released and idle.
    repeat (3) step();
    reset = 1'b1;
    repeat (3) step();

    // Entering, then exiting, then simultaneous requests.
    req_in = 1'b1; step(); req_in = 1'b0; repeat (17) step();
    req_out = 1'b1; step(); req_out = 1'b0; repeat (17) step();
    req_in = 1'b1; req_out = 1'b1; step();
    req_in = 1'b0; req_out = 1'b0; repeat (17) step();

    // Busy request ignored: exactly one done pulse.
    done_seen = 0;
    req_in = 1'b1; step(); req_in = 1'b0;
    repeat (5) step();
    req_out = 1'b1; step(); req_out = 1'b0;
    repeat (12) step();
    check("done_count", 8'(done_seen), 8'd1);

    // Request held through the done cycle: back-to-back sequences.
    req_in = 1'b1; step(); repeat (17) step(); req_in = 1'b0;
    repeat (17) step();

    // Reset mid-sequence drops the lines immediately.
    req_in = 1'b1; step(); req_in = 1'b0;
    repeat (6) step();
    #2 reset = 1'b0;
    #1;
    check("rst_ab",    {6'd0, a, b}, 8'd0);
    check("rst_ready", {7'd0, ready}, 8'd1);
    check("rst_done",  {7'd0, done}, 8'd0);
    repeat (2) step();
    reset = 1'b1;
    repeat (3) step();

    if (ABORT_EN) begin
      // Abort sampled in P2 backs the car out; abort sampled in P3 is ignored.
      req_in = 1'b1; step(); req_in = 1'b0;
      repeat (5) step();
      abort = 1'b1; step(); abort = 1'b0;
      repeat (10) step();
      req_in = 1'b1; step(); req_in = 1'b0;
      repeat (8) step();
      abort = 1'b1; step(); abort = 1'b0;
      repeat (10) step();
    end

    // Random requests, aborts and occasional resets.
    repeat (2000) begin
      req_in  = ($urandom_range(0, 9) == 0);
      req_out = ($urandom_range(0, 9) == 0);
      abort   = ABORT_EN && ($urandom_range(0, 15) == 0);
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 299) == 0) reset = 1'b0;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
